// File: rtl/sc_behavior_arbiter_pkg.sv
// Shared constants for the behaviour arbiter: state codes,
// stop-cause bit positions and select-code helpers.
package sc_behavior_arbiter_pkg;

    localparam logic [1:0] ST_RESET = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam int CAUSE_STOP = 0;
    localparam int CAUSE_GOAL = 1;

    localparam int IDLE_CODE = 0;

    function automatic int sel_code(input int idx);
        return idx + 1;
    endfunction

endpackage

// File: rtl/sc_behavior_arbiter_if.sv
// Flag/request inputs and mux-select outputs of the arbiter,
// bundled between the flag logic (master) and the arbiter (slave).
interface sc_behavior_arbiter_if #(
    parameter int NUM_CTRL = 2,
    parameter int SEL_W    = $clog2(NUM_CTRL + 2)
);
    logic [NUM_CTRL-1:0] SC_BEHAVIORARBITER_REQ_InBus;
    logic                SC_BEHAVIORARBITER_NEWSIGNAL_InLow;
    logic                SC_BEHAVIORARBITER_STOP_InLow;
    logic                SC_BEHAVIORARBITER_FLAGGOAL_InLow;
    logic [SEL_W-1:0]    SC_BEHAVIORARBITER_MUXSELECT_OutBus;
    logic [NUM_CTRL-1:0] SC_BEHAVIORARBITER_ACTIVE_OutBus;
    logic [1:0]          SC_BEHAVIORARBITER_STOPCAUSE_OutBus;
    logic                SC_BEHAVIORARBITER_SWITCH_OutLow;

    modport master (
        output SC_BEHAVIORARBITER_REQ_InBus,
        output SC_BEHAVIORARBITER_NEWSIGNAL_InLow,
        output SC_BEHAVIORARBITER_STOP_InLow,
        output SC_BEHAVIORARBITER_FLAGGOAL_InLow,
        input  SC_BEHAVIORARBITER_MUXSELECT_OutBus,
        input  SC_BEHAVIORARBITER_ACTIVE_OutBus,
        input  SC_BEHAVIORARBITER_STOPCAUSE_OutBus,
        input  SC_BEHAVIORARBITER_SWITCH_OutLow
    );

    modport slave (
        input  SC_BEHAVIORARBITER_REQ_InBus,
        input  SC_BEHAVIORARBITER_NEWSIGNAL_InLow,
        input  SC_BEHAVIORARBITER_STOP_InLow,
        input  SC_BEHAVIORARBITER_FLAGGOAL_InLow,
        output SC_BEHAVIORARBITER_MUXSELECT_OutBus,
        output SC_BEHAVIORARBITER_ACTIVE_OutBus,
        output SC_BEHAVIORARBITER_STOPCAUSE_OutBus,
        output SC_BEHAVIORARBITER_SWITCH_OutLow
    );

endinterface

// File: rtl/sc_behavior_arbiter_encoder.sv
// Highest-set-bit priority encoder used to pick the winning
// request channel; purely combinational.
module sc_priority_encoder #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    output logic          valid,
    output logic [IW-1:0] idx
);

    // Later (higher) indices overwrite earlier ones, so the top bit wins.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                valid = 1'b1;
                idx   = IW'(i);
            end
        end
    end

endmodule

// File: rtl/sc_behavior_arbiter.sv
// Behaviour arbiter: picks the motion controller driving the motor mux,
// with start settle delay, minimum dwell, preemption and latched stop cause.
module sc_behavior_arbiter
    import sc_behavior_arbiter_pkg::*;
#(
    parameter int NUM_CTRL    = 2,
    parameter int START_DELAY = 4,
    parameter int MIN_DWELL   = 8,
    parameter int PREEMPT     = 1,
    parameter int SEL_W       = $clog2(NUM_CTRL + 2)
) (
    input logic                  SC_BEHAVIORARBITER_CLOCK_50,
    input logic                  SC_BEHAVIORARBITER_RESET_InLow,
    sc_behavior_arbiter_if.slave arb
);

    localparam int IDX_W   = (NUM_CTRL > 1) ? $clog2(NUM_CTRL) : 1;
    localparam int CNT_MAX = (START_DELAY > MIN_DWELL) ? START_DELAY : MIN_DWELL;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]    START_LIM = CNT_W'(START_DELAY);
    localparam logic [CNT_W-1:0]    DWELL_LIM = CNT_W'(MIN_DWELL);
    localparam logic [NUM_CTRL-1:0] ONE_HOT0  = NUM_CTRL'(1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc, cnt_lim;
    logic [IDX_W-1:0] cur_q, cur_d;
    logic [1:0]       cause_q, cause_d;
    logic             switch_n_q, switch_n_d;
    logic             newsig_q;
    logic             win_vld;
    logic [IDX_W-1:0] win_idx;
    logic             halt;
    logic             restart;
    logic             do_switch;
    logic [1:0]       cause_now;

    sc_priority_encoder #(
        .N  (NUM_CTRL),
        .IW (IDX_W)
    ) u_winner (
        .req   (arb.SC_BEHAVIORARBITER_REQ_InBus),
        .valid (win_vld),
        .idx   (win_idx)
    );

    // Stop/goal level, restart edge, saturating count and switch decision.
    always_comb begin
        halt    = ~arb.SC_BEHAVIORARBITER_STOP_InLow
                | ~arb.SC_BEHAVIORARBITER_FLAGGOAL_InLow;
        restart = newsig_q & ~arb.SC_BEHAVIORARBITER_NEWSIGNAL_InLow;
        cause_now             = 2'b00;
        cause_now[CAUSE_STOP] = ~arb.SC_BEHAVIORARBITER_STOP_InLow;
        cause_now[CAUSE_GOAL] = ~arb.SC_BEHAVIORARBITER_FLAGGOAL_InLow;
        cnt_lim = (state_q == ST_RUN) ? DWELL_LIM : START_LIM;
        cnt_inc = (cnt_q >= cnt_lim) ? cnt_lim : cnt_q + 1'b1;
        do_switch = win_vld && (win_idx != cur_q)
                 && ((cnt_inc >= DWELL_LIM)
                     || ((PREEMPT != 0) && (win_idx > cur_q)));
    end

    // Next-state logic; counts compare against the value after this cycle.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cur_d      = cur_q;
        cause_d    = cause_q;
        switch_n_d = 1'b1;
        case (state_q)
            ST_RESET: begin
                state_d = ST_START;
                cnt_d   = '0;
            end
            ST_START: begin
                cnt_d = cnt_inc;
                if (halt) begin
                    state_d = ST_STOP;
                    cause_d = cause_now;
                end else if ((cnt_inc >= START_LIM) && win_vld) begin
                    state_d = ST_RUN;
                    cur_d   = win_idx;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                cnt_d = cnt_inc;
                if (halt) begin
                    state_d = ST_STOP;
                    cause_d = cause_now;
                end else if (do_switch) begin
                    cur_d      = win_idx;
                    cnt_d      = '0;
                    switch_n_d = 1'b0;
                end
            end
            ST_STOP: begin
                if (restart) begin
                    state_d = ST_START;
                    cause_d = 2'b00;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_RESET;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge SC_BEHAVIORARBITER_CLOCK_50
                or negedge SC_BEHAVIORARBITER_RESET_InLow) begin
        if (!SC_BEHAVIORARBITER_RESET_InLow) begin
            state_q    <= ST_RESET;
            cnt_q      <= '0;
            cur_q      <= '0;
            cause_q    <= 2'b00;
            switch_n_q <= 1'b1;
            newsig_q   <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cur_q      <= cur_d;
            cause_q    <= cause_d;
            switch_n_q <= switch_n_d;
            newsig_q   <= arb.SC_BEHAVIORARBITER_NEWSIGNAL_InLow;
        end
    end

    // Outputs decode directly from registered state.
    always_comb begin
        arb.SC_BEHAVIORARBITER_MUXSELECT_OutBus = SEL_W'(IDLE_CODE);
        arb.SC_BEHAVIORARBITER_ACTIVE_OutBus    = '0;
        if (state_q == ST_RUN) begin
            arb.SC_BEHAVIORARBITER_MUXSELECT_OutBus =
                SEL_W'(sel_code(int'(cur_q)));
            arb.SC_BEHAVIORARBITER_ACTIVE_OutBus = ONE_HOT0 << cur_q;
        end else if (state_q == ST_STOP) begin
            arb.SC_BEHAVIORARBITER_MUXSELECT_OutBus = SEL_W'(NUM_CTRL + 1);
        end
        arb.SC_BEHAVIORARBITER_STOPCAUSE_OutBus = cause_q;
        arb.SC_BEHAVIORARBITER_SWITCH_OutLow    = switch_n_q;
    end

endmodule

// File: tb/tb_sc_behavior_arbiter.sv
// Directed bench: a preempting and a non-preempting arbiter
// share one stimulus stream; expectations are hand-computed.
module tb_sc_behavior_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [1:0] req = 2'b01;
    logic       nsig = 1'b1;
    logic       stp = 1'b1;
    logic       goal = 1'b1;
    int         n_chk = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    sc_behavior_arbiter_if #(.NUM_CTRL(2)) p_if ();
    sc_behavior_arbiter_if #(.NUM_CTRL(2)) np_if ();

    assign p_if.SC_BEHAVIORARBITER_REQ_InBus        = req;
    assign p_if.SC_BEHAVIORARBITER_NEWSIGNAL_InLow  = nsig;
    assign p_if.SC_BEHAVIORARBITER_STOP_InLow       = stp;
    assign p_if.SC_BEHAVIORARBITER_FLAGGOAL_InLow   = goal;
    assign np_if.SC_BEHAVIORARBITER_REQ_InBus       = req;
    assign np_if.SC_BEHAVIORARBITER_NEWSIGNAL_InLow = nsig;
    assign np_if.SC_BEHAVIORARBITER_STOP_InLow      = stp;
    assign np_if.SC_BEHAVIORARBITER_FLAGGOAL_InLow  = goal;

    sc_behavior_arbiter #(
        .NUM_CTRL(2), .START_DELAY(4), .MIN_DWELL(8), .PREEMPT(1)
    ) dut (
        .SC_BEHAVIORARBITER_CLOCK_50    (clk),
        .SC_BEHAVIORARBITER_RESET_InLow (rst_n),
        .arb                            (p_if.slave)
    );

    sc_behavior_arbiter #(
        .NUM_CTRL(2), .START_DELAY(4), .MIN_DWELL(8), .PREEMPT(0)
    ) dut_np (
        .SC_BEHAVIORARBITER_CLOCK_50    (clk),
        .SC_BEHAVIORARBITER_RESET_InLow (rst_n),
        .arb                            (np_if.slave)
    );

    task automatic chk(input string tag, input int unsigned got,
                       input int unsigned exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_p(input string tag, input int unsigned mux,
                         input int unsigned act, input int unsigned sw);
        chk({tag, "_mux"}, p_if.SC_BEHAVIORARBITER_MUXSELECT_OutBus, mux);
        chk({tag, "_act"}, p_if.SC_BEHAVIORARBITER_ACTIVE_OutBus, act);
        chk({tag, "_sw"}, p_if.SC_BEHAVIORARBITER_SWITCH_OutLow, sw);
    endtask

    task automatic chk_np(input string tag, input int unsigned mux,
                          input int unsigned act, input int unsigned sw);
        chk({tag, "_np_mux"}, np_if.SC_BEHAVIORARBITER_MUXSELECT_OutBus, mux);
        chk({tag, "_np_act"}, np_if.SC_BEHAVIORARBITER_ACTIVE_OutBus, act);
        chk({tag, "_np_sw"}, np_if.SC_BEHAVIORARBITER_SWITCH_OutLow, sw);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #17;
        chk_p("rst", 0, 0, 1);
        chk("rst_cause", p_if.SC_BEHAVIORARBITER_STOPCAUSE_OutBus, 0);
        #4 rst_n = 1'b1;
        chk_p("reset_st", 0, 0, 1);

        // 1: four START cycles, then channel 0
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk_p($sformatf("start%0d", i), 0, 0, 1);
        end
        tick();
        chk_p("run0", 1, 1, 1);
        chk_np("run0", 1, 1, 1);

        // 2: preempt at dwell 2; non-preempt waits for dwell 8
        repeat (2) tick();
        req = 2'b11;
        tick();
        chk_p("preempt", 2, 2, 0);
        chk_np("nopre_hold", 1, 1, 1);
        tick();
        chk_p("preempt_pulse_end", 2, 2, 1);
        repeat (3) tick();
        chk_np("nopre_e7", 1, 1, 1);
        tick();
        chk_np("nopre_sw", 2, 2, 0);
        chk_p("p_e8", 2, 2, 1);

        // 3: lower priority deferred until dwell expires
        req = 2'b01;
        repeat (2) tick();
        chk_p("defer_e10", 2, 2, 1);
        tick();
        chk_p("defer_sw", 1, 1, 0);
        chk_np("defer_np_e11", 2, 2, 1);
        repeat (4) tick();
        chk_np("defer_np_e15", 2, 2, 1);
        tick();
        chk_np("defer_np_sw", 1, 1, 0);
        req = 2'b00;
        repeat (3) tick();
        chk_p("none_hold", 1, 1, 1);
        chk_np("none_hold", 1, 1, 1);

        // 4: stop+goal beat a pending preempt
        req  = 2'b11;
        stp  = 1'b0;
        goal = 1'b0;
        tick();
        chk_p("stop", 3, 0, 1);
        chk("stop_cause", p_if.SC_BEHAVIORARBITER_STOPCAUSE_OutBus, 3);
        chk("stop_cause_np", np_if.SC_BEHAVIORARBITER_STOPCAUSE_OutBus, 3);

        // 5: restart on falling edge, held low ten cycles
        stp  = 1'b1;
        goal = 1'b1;
        repeat (2) tick();
        chk_p("stop_hold", 3, 0, 1);
        chk("stop_hold_cause", p_if.SC_BEHAVIORARBITER_STOPCAUSE_OutBus, 3);
        nsig = 1'b0;
        tick();
        chk_p("restart", 0, 0, 1);
        chk("restart_cause", p_if.SC_BEHAVIORARBITER_STOPCAUSE_OutBus, 0);
        repeat (3) tick();
        chk_p("restart_e26", 0, 0, 1);
        tick();
        chk_p("restart_run", 2, 2, 1);
        chk_np("restart_run", 2, 2, 1);
        repeat (5) tick();
        chk_p("nsig_held", 2, 2, 1);
        nsig = 1'b1;

        stp = 1'b0;
        tick();
        chk_p("stop2", 3, 0, 1);
        chk("stop2_cause", p_if.SC_BEHAVIORARBITER_STOPCAUSE_OutBus, 1);
        tick();
        nsig = 1'b0;
        tick();
        chk_p("start_stoplow", 0, 0, 1);
        chk("start_cause", p_if.SC_BEHAVIORARBITER_STOPCAUSE_OutBus, 0);
        tick();
        chk_p("back_stop", 3, 0, 1);
        chk("back_cause", p_if.SC_BEHAVIORARBITER_STOPCAUSE_OutBus, 1);
        stp = 1'b1;
        tick();
        chk_p("no_retrig", 3, 0, 1);

        // 6: asynchronous reset in the middle of RUN
        nsig = 1'b1;
        tick();
        nsig = 1'b0;
        repeat (5) tick();
        chk_p("run_again", 2, 2, 1);
        #2 rst_n = 1'b0;
        #1;
        chk_p("async_rst", 0, 0, 1);
        chk("async_cause", p_if.SC_BEHAVIORARBITER_STOPCAUSE_OutBus, 0);
        chk_np("async_rst", 0, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
